// File: rtl/fwht_pkg.sv
// Shared constants and helpers for the SDF Walsh-Hadamard sequencer.
package fwht_pkg;

    localparam logic [1:0] CTR_FILL = 2'b00;
    localparam logic [1:0] CTR_SUM  = 2'b01;
    localparam logic [1:0] CTR_DIFF = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD,
        ST_FLUSH
    } flush_state_t;

    // FIFO depth of stage s: 2^(LOG_N-1-s).
    function automatic int unsigned stage_delay(input int unsigned s, input int unsigned log_n);
        return 32'd1 << (log_n - 32'd1 - s);
    endfunction

endpackage

// File: rtl/fwht_stage_seq.sv
// Per-stage phase counter, pending-difference flag and control decode for one SDF stage.
module fwht_stage_seq
    import fwht_pkg::*;
#(
    parameter int LOG_N = 3,
    parameter int CNT_W = LOG_N,
    parameter int STAGE = 0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic       i_v_in,
    output logic [1:0] o_ctr,
    output logic       o_wr,
    output logic       o_rd,
    output logic       o_active
);
    localparam int unsigned D = stage_delay(STAGE, LOG_N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * D - 1);
    localparam logic [CNT_W-1:0] MID  = CNT_W'(D - 1);

    logic             v;
    logic             pend;
    logic             h;
    logic [CNT_W-1:0] cnt;

    assign h        = cnt[LOG_N-1-STAGE];
    assign o_active = v | pend;

    always_comb begin
        o_ctr = CTR_FILL;
        o_wr  = 1'b0;
        o_rd  = 1'b0;
        if (v) begin
            o_wr = 1'b1;
            if (h) begin
                o_ctr = CTR_SUM;
                o_rd  = 1'b1;
            end else if (pend) begin
                o_ctr = CTR_DIFF;
                o_rd  = 1'b1;
            end
        end else if (pend) begin
            o_ctr = CTR_DIFF;
            o_rd  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v    <= 1'b0;
            pend <= 1'b0;
            cnt  <= '0;
        end else if (i_ce) begin
            v <= i_v_in;
            if (v | pend)
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            else
                cnt <= '0;
            if (v & h & (cnt == LAST))
                pend <= 1'b1;
            else if (pend & (cnt == MID))
                pend <= 1'b0;
        end
    end

endmodule

// File: rtl/fwht_sdf_ctrl.sv
// Sequencer for a LOG_N-stage SDF Fast Walsh-Hadamard pipeline: clock enable, flush and output framing.
// Optional FWHT_CTRL_STATS_EN adds o_frame_cnt, a 16-bit count of frames leaving the last stage.
module fwht_sdf_ctrl
    import fwht_pkg::*;
#(
    parameter int LOG_N = 3,
    parameter int CNT_W = LOG_N
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_flush,
    output logic               o_ce,
    output logic [2*LOG_N-1:0] o_ctr,
    output logic [LOG_N-1:0]   o_wr,
    output logic [LOG_N-1:0]   o_rd,
    output logic               o_out_valid,
    output logic               o_frame_start,
    output logic               o_busy
`ifdef FWHT_CTRL_STATS_EN
    ,
    output logic [15:0]        o_frame_cnt
`endif
);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'((1 << LOG_N) - 1);

    flush_state_t       state;
    logic               run;
    logic               flushing;
    logic               accept;
    logic               ce;
    logic               busy;
    logic               out_fire;
    logic [CNT_W-1:0]   in_cnt;
    logic [CNT_W-1:0]   in_cnt_nxt;
    logic [CNT_W-1:0]   out_cnt;
    logic [2*LOG_N-1:0] ctr;
    logic [LOG_N-1:0]   wr;
    logic [LOG_N-1:0]   rd;
    logic [LOG_N-1:0]   active;
    logic [LOG_N-1:0]   v_in;
    logic [1:0]         last_ctr;

    assign run      = ~i_reset;
    assign flushing = (state == ST_FLUSH);
    assign accept   = run & i_valid & ~flushing;
    assign ce       = accept | (run & flushing);
    assign busy     = |active;
    assign last_ctr = ctr[2*LOG_N-1 -: 2];
    assign out_fire = (last_ctr != CTR_FILL) & ce;

    assign o_ready       = run & ~flushing;
    assign o_ce          = ce;
    assign o_ctr         = run ? ctr : '0;
    assign o_wr          = wr & {LOG_N{ce}};
    assign o_rd          = rd & {LOG_N{ce}};
    assign o_out_valid   = out_fire;
    assign o_frame_start = out_fire & (out_cnt == '0);
    assign o_busy        = run & busy;

    for (genvar s = 0; s < LOG_N; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign v_in[s] = i_valid & ~flushing;
        end else begin : g_tail
            assign v_in[s] = (ctr[2*s-2 +: 2] != CTR_FILL);
        end
        fwht_stage_seq #(
            .LOG_N(LOG_N),
            .CNT_W(CNT_W),
            .STAGE(s)
        ) u_seq (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_ce    (ce),
            .i_v_in  (v_in[s]),
            .o_ctr   (ctr[2*s +: 2]),
            .o_wr    (wr[s]),
            .o_rd    (rd[s]),
            .o_active(active[s])
        );
    end

    always_comb begin
        in_cnt_nxt = in_cnt;
        if (accept)
            in_cnt_nxt = (in_cnt == N_LAST) ? '0 : in_cnt + CNT_W'(1);
    end

`ifdef FWHT_CTRL_STATS_EN
    logic [15:0] frame_cnt;
    assign o_frame_cnt = run ? frame_cnt : '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_RUN;
            in_cnt  <= '0;
            out_cnt <= '0;
`ifdef FWHT_CTRL_STATS_EN
            frame_cnt <= '0;
`endif
        end else begin
            in_cnt <= in_cnt_nxt;
            if (out_fire) begin
                out_cnt <= (out_cnt == N_LAST) ? '0 : out_cnt + CNT_W'(1);
`ifdef FWHT_CTRL_STATS_EN
                if (out_cnt == N_LAST)
                    frame_cnt <= frame_cnt + 16'd1;
`endif
            end
            case (state)
                ST_RUN, ST_HOLD: begin
                    // Boundary test uses the post-accept count so no extra sample slips in.
                    if (i_flush | (state == ST_HOLD)) begin
                        if (in_cnt_nxt != '0)
                            state <= ST_HOLD;
                        else if (busy | accept)
                            state <= ST_FLUSH;
                        else
                            state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (!busy)
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
